slice_packer: RTL and testbench

Sequential counterpart of the team's packed-slice selector. It accepts a stream of BUS_SIZE-wide words and writes each one into successive slices of a NUM_SLICES*BUS_SIZE packed register. When every slice is filled, it presents the assembled word with a valid/ready handshake. Typical use is assembling UART bytes into 32-bit instruction/data words for loading into MIPS instruction memory. Slice k occupies bits [k*BUS_SIZE +: BUS_SIZE], so the selector reads back exactly what this block wrote.

---
 rtl/slice_packer.sv | 79 +++++++
 tb/tb_slice_packer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/slice_packer.sv
// Assembles a stream of BUS_SIZE words into one NUM_SLICES*BUS_SIZE word,
// filling slice 0 upward, then holds it under a valid/ready handshake.
//
// state | meaning
// FILL  | accepting input words into o_data[o_slice]
// HOLD  | assembled word presented on o_data, waiting for i_ready
module slice_packer #(
  parameter  int BITS_ENABLES = 2,
  parameter  int BUS_SIZE     = 8,
  localparam int NUM_SLICES   = 2**BITS_ENABLES
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_flush,
  input  logic                           i_valid,
  input  logic [BUS_SIZE-1:0]            i_data,
  output logic                           o_ready,
  output logic [NUM_SLICES*BUS_SIZE-1:0] o_data,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [BITS_ENABLES-1:0]        o_slice
);

  typedef enum logic {FILL, HOLD} state_t;

  localparam logic [BITS_ENABLES-1:0] LAST_SLICE = BITS_ENABLES'(NUM_SLICES - 1);
  localparam logic [BITS_ENABLES-1:0] ONE        = BITS_ENABLES'(1);

  state_t state;

  // o_valid/o_ready are registered copies of the state so no input reaches them
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= FILL;
      o_slice <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
    end else if (i_flush) begin
      state   <= FILL;
      o_slice <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
    end else begin
      case (state)
        FILL: begin
          if (i_valid) begin
            o_data[int'(o_slice)*BUS_SIZE +: BUS_SIZE] <= i_data;
            if (o_slice == LAST_SLICE) begin
              o_slice <= '0;
              state   <= HOLD;
              o_valid <= 1'b1;
              o_ready <= 1'b0;
            end else begin
              o_slice <= o_slice + ONE;
            end
          end
        end
        HOLD: begin
          if (i_ready) begin
            state   <= FILL;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        default: begin
          state   <= FILL;
          o_slice <= '0;
          o_data  <= '0;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slice_packer.sv
// Scoreboard bench for slice_packer: default 4x8 instance plus a 2x16 variant.
module tb_slice_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, valid, ready;
  logic [7:0]  data;
  logic        o_ready, o_valid;
  logic [31:0] o_data;
  logic [1:0]  o_slice;

  logic        flush2, valid2, ready2;
  logic [15:0] data2;
  logic        o_ready2, o_valid2;
  logic [31:0] o_data2;
  logic [0:0]  o_slice2;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_q2[$];
  logic [31:0] exp;

  always #5 clk = ~clk;

  slice_packer dut (
    .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_valid(valid), .i_data(data),
    .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .i_ready(ready),
    .o_slice(o_slice)
  );

  slice_packer #(.BITS_ENABLES(1), .BUS_SIZE(16)) dut16 (
    .i_clk(clk), .i_reset(rst), .i_flush(flush2), .i_valid(valid2), .i_data(data2),
    .o_ready(o_ready2), .o_data(o_data2), .o_valid(o_valid2), .i_ready(ready2),
    .o_slice(o_slice2)
  );

  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk);
    valid = v;
    data  = d;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 0; valid = 0; data = 8'h00; ready = 0;
    flush2 = 0; valid2 = 0; data2 = 16'h0000; ready2 = 0;
    #12;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", o_data); end
    checks++; if (o_slice !== 2'd0) begin errors++; $display("FAIL reset_slice got=%0d exp=0", o_slice); end
    @(negedge clk); rst = 1'b0;
    cycle();
    checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle got rdy=%b vld=%b exp rdy=1 vld=0", o_ready, o_valid); end
  endtask

  task automatic test_basic();
    logic [7:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    ready = 1'b1;
    exp_q.push_back(32'h44332211);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, b[i]);
      cycle();
      checks++; if (o_slice !== 2'(i + 1)) begin errors++; $display("FAIL basic_slice%0d got=%0d exp=%0d", i, o_slice, 2'(i + 1)); end
      if (i < 3) begin
        checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL basic_fill%0d got vld=%b rdy=%b exp vld=0 rdy=1", i, o_valid, o_ready); end
      end
    end
    exp = exp_q.pop_front();
    checks++; if (o_valid !== 1'b1 || o_ready !== 1'b0) begin errors++; $display("FAIL basic_hold got vld=%b rdy=%b exp vld=1 rdy=0", o_valid, o_ready); end
    checks++; if (o_data !== exp) begin errors++; $display("FAIL basic_data got=%h exp=%h", o_data, exp); end
    drive(1'b0, 8'hFF);
    cycle();
    checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_data !== 32'h0) begin errors++; $display("FAIL basic_release got vld=%b rdy=%b data=%h exp 0 1 0", o_valid, o_ready, o_data); end
  endtask

  task automatic test_backpressure();
    logic [7:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] c [4] = '{8'h55, 8'h66, 8'h77, 8'h88};
    ready = 1'b0;
    exp_q.push_back(32'h44332211);
    for (int i = 0; i < 4; i++) begin drive(1'b1, b[i]); cycle(); end
    drive(1'b1, 8'hEE);
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++; if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_data !== exp_q[0]) begin errors++; $display("FAIL bp_hold%0d got vld=%b rdy=%b data=%h exp 1 0 %h", i, o_valid, o_ready, o_data, exp_q[0]); end
    end
    @(negedge clk); ready = 1'b1; valid = 1'b0;
    exp = exp_q.pop_front();
    checks++; if (o_data !== exp) begin errors++; $display("FAIL bp_data got=%h exp=%h", o_data, exp); end
    cycle();
    checks++; if (o_valid !== 1'b0 || o_slice !== 2'd0 || o_data !== 32'h0) begin errors++; $display("FAIL bp_release got vld=%b slice=%0d data=%h exp 0 0 0", o_valid, o_slice, o_data); end
    exp_q.push_back(32'h88776655);
    for (int i = 0; i < 4; i++) begin drive(1'b1, c[i]); cycle(); end
    exp = exp_q.pop_front();
    checks++; if (o_valid !== 1'b1 || o_data !== exp) begin errors++; $display("FAIL bp_refill got vld=%b data=%h exp 1 %h", o_valid, o_data, exp); end
    drive(1'b0, 8'h00);
    cycle();
  endtask

  task automatic test_gaps();
    ready = 1'b0;
    exp_q.push_back(32'hDDCCBBAA);
    drive(1'b1, 8'hAA); cycle();
    for (int i = 0; i < 3; i++) begin drive(1'b0, 8'h5A); cycle(); end
    checks++; if (o_slice !== 2'd1 || o_data !== 32'h000000AA) begin errors++; $display("FAIL gap_idle got slice=%0d data=%h exp 1 000000aa", o_slice, o_data); end
    drive(1'b1, 8'hBB); cycle();
    drive(1'b0, 8'hC3); cycle();
    drive(1'b1, 8'hCC); cycle();
    drive(1'b1, 8'hDD); cycle();
    exp = exp_q.pop_front();
    checks++; if (o_valid !== 1'b1 || o_data !== exp) begin errors++; $display("FAIL gap_data got vld=%b data=%h exp 1 %h", o_valid, o_data, exp); end
    @(negedge clk); valid = 1'b0; ready = 1'b1;
    cycle();
  endtask

  task automatic test_flush();
    logic [7:0] b [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    ready = 1'b0;
    drive(1'b1, 8'h01); cycle();
    drive(1'b1, 8'h02); cycle();
    @(negedge clk); flush = 1'b1; valid = 1'b1; data = 8'h03;
    cycle();
    checks++; if (o_slice !== 2'd0 || o_data !== 32'h0 || o_ready !== 1'b1) begin errors++; $display("FAIL flush_fill got slice=%0d data=%h rdy=%b exp 0 0 1", o_slice, o_data, o_ready); end
    @(negedge clk); flush = 1'b0; valid = 1'b0;
    exp_q.push_back(32'hD4C3B2A1);
    for (int i = 0; i < 4; i++) begin drive(1'b1, b[i]); cycle(); end
    checks++; if (o_valid !== 1'b1 || o_data !== exp_q[0]) begin errors++; $display("FAIL flush_refill got vld=%b data=%h exp 1 %h", o_valid, o_data, exp_q[0]); end
    @(negedge clk); valid = 1'b0; flush = 1'b1; ready = 1'b1;
    void'(exp_q.pop_front());
    cycle();
    checks++; if (o_valid !== 1'b0 || o_data !== 32'h0 || o_ready !== 1'b1) begin errors++; $display("FAIL flush_hold got vld=%b data=%h rdy=%b exp 0 0 1", o_valid, o_data, o_ready); end
    @(negedge clk); flush = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [7:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin drive(1'b1, b[i]); cycle(); end
    @(negedge clk); valid = 1'b0;
    checks++; if (o_valid !== 1'b1 || o_data !== 32'h44332211) begin errors++; $display("FAIL ar_pre got vld=%b data=%h exp 1 44332211", o_valid, o_data); end
    #1 rst = 1'b1;
    #1;
    checks++; if (o_valid !== 1'b0 || o_data !== 32'h0 || o_slice !== 2'd0 || o_ready !== 1'b1) begin errors++; $display("FAIL ar_async got vld=%b data=%h slice=%0d rdy=%b exp 0 0 0 1", o_valid, o_data, o_slice, o_ready); end
    #1 rst = 1'b0;
    ready = 1'b1;
    exp_q.push_back(32'h04030201);
    for (int i = 0; i < 4; i++) begin drive(1'b1, 8'(i + 1)); cycle(); end
    exp = exp_q.pop_front();
    checks++; if (o_valid !== 1'b1 || o_data !== exp) begin errors++; $display("FAIL ar_resume got vld=%b data=%h exp 1 %h", o_valid, o_data, exp); end
    drive(1'b0, 8'h00);
    cycle();
  endtask

  task automatic test_wide_variant();
    ready2 = 1'b1;
    exp_q2.push_back(32'hABCD1234);
    @(negedge clk); valid2 = 1'b1; data2 = 16'h1234;
    cycle();
    checks++; if (o_slice2 !== 1'b1 || o_valid2 !== 1'b0) begin errors++; $display("FAIL w16_slice1 got slice=%0d vld=%b exp 1 0", o_slice2, o_valid2); end
    @(negedge clk); data2 = 16'hABCD;
    cycle();
    exp = exp_q2.pop_front();
    checks++; if (o_slice2 !== 1'b0 || o_valid2 !== 1'b1 || o_data2 !== exp) begin errors++; $display("FAIL w16_word got slice=%0d vld=%b data=%h exp 0 1 %h", o_slice2, o_valid2, o_data2, exp); end
    @(negedge clk); valid2 = 1'b0;
    cycle();
    checks++; if (o_valid2 !== 1'b0 || o_data2 !== 32'h0) begin errors++; $display("FAIL w16_release got vld=%b data=%h exp 0 0", o_valid2, o_data2); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_flush();
    test_async_reset();
    test_wide_variant();
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
